// File: rtl/sdr_rd_rsp_fifo_pkg.sv
// Shared types and constants for the SDRAM read-response FIFO.
// Holds the APB FSM state, status bit layout and the stored entry.
package sdr_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [15:0] DEF_DATA_ADDR = 16'h0100;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0104;

  localparam int ST_OVF   = 15;
  localparam int ST_FULL  = 14;
  localparam int ST_EMPTY = 13;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } rsp_entry_t;

  function automatic logic [15:0] stat_word(
    input logic        ovf,
    input logic        full,
    input logic        empty,
    input logic [11:0] cnt
  );
    logic [15:0] w;
    w           = '0;
    w[11:0]     = cnt;
    w[ST_OVF]   = ovf;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    return w;
  endfunction

endpackage

// File: rtl/sdr_rd_rsp_fifo_if.sv
// APB slave bus bundle for the read-response FIFO.
// Master drives address/control, slave returns data/ready/error.
interface sdr_rd_rsp_fifo_if;

  logic        pselect;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output pselect, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselect, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/sdr_rd_rsp_fifo_buf.sv
// In-order storage for returned read data.
// Occupancy is tracked by count; pointers wrap naturally.
module sdr_rsp_buf
  import sdr_rsp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  rsp_entry_t             push_entry,
  input  logic                   pop,
  output rsp_entry_t             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  rsp_entry_t mem_q [DEPTH];
  rsp_entry_t mem_d [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; only written slots are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = cnt_q;
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sdr_rd_rsp_fifo.sv
// Read-response FIFO: buffers SDRAM read data for APB readback.
// Data reads wait while empty and fail after a bounded timeout.
module sdr_rd_rsp_fifo
  import sdr_rsp_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 255,
  parameter logic [15:0] DATA_ADDR  = DEF_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR  = DEF_STAT_ADDR
) (
  input  logic                        pclk,
  input  logic                        presetn,
  sdr_rd_rsp_fifo_if.slave            bus,
  input  logic                        rsp_valid,
  input  logic [15:0]                 rsp_addr,
  input  logic [15:0]                 rsp_data,
  output logic                        rsp_ready,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [15:0] prdata_q, prdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        ovf_q, ovf_d;

  logic       push, pop;
  rsp_entry_t push_entry, head;
  logic       access, tmo_done;
  logic       is_data_rd, is_stat_rd, is_stat_wr;
  logic       ovf_clr;

  sdr_rsp_buf #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk        (pclk),
    .rst_n      (presetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign push       = rsp_valid && !fifo_full;
  assign push_entry = '{addr: rsp_addr, data: rsp_data};
  assign rsp_ready  = !fifo_full;

  assign access     = bus.pselect && bus.penable && !pready_q;
  assign is_data_rd = !bus.pwrite && (bus.paddr == DATA_ADDR);
  assign is_stat_rd = !bus.pwrite && (bus.paddr == STAT_ADDR);
  assign is_stat_wr = bus.pwrite && (bus.paddr == STAT_ADDR);
  assign tmo_done   = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = (is_data_rd && fifo_empty) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (!bus.pselect) begin
          state_d = IDLE;
        end else if (!fifo_empty || tmo_done) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    tmo_d     = tmo_q;
    pop       = 1'b0;
    ovf_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          unique case (1'b1)
            is_data_rd && !fifo_empty: begin
              pop      = 1'b1;
              prdata_d = head.data;
              pready_d = 1'b1;
            end
            is_data_rd && fifo_empty: begin
              tmo_d = '0;
            end
            is_stat_rd: begin
              prdata_d = stat_word(ovf_q, fifo_full, fifo_empty,
                                   12'(fifo_count));
              pready_d = 1'b1;
            end
            is_stat_wr: begin
              ovf_clr  = bus.pwdata[ST_OVF];
              pready_d = 1'b1;
            end
            default: begin
              prdata_d  = '0;
              pslverr_d = 1'b1;
              pready_d  = 1'b1;
            end
          endcase
        end
      end
      WAIT: begin
        if (!bus.pselect) begin
          tmo_d = tmo_q;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          prdata_d = head.data;
          pready_d = 1'b1;
        end else if (tmo_done) begin
          prdata_d  = '0;
          pslverr_d = 1'b1;
          pready_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
      end
    endcase
    // A drop in the same cycle as a clear keeps the flag set.
    if (rsp_valid && fifo_full) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.prdata  = prdata_q;
  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign overflow    = ovf_q;

  pop_has_addr: assert property (
    @(posedge pclk) disable iff (!presetn)
    pop |-> !$isunknown(head.addr)
  );

endmodule

// File: tb/tb_sdr_rd_rsp_fifo.sv
// Self-checking bench for sdr_rd_rsp_fifo.
// Directed scenarios plus random traffic against a queue model.
module tb_sdr_rd_rsp_fifo;
  import sdr_rsp_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          TMO   = 255;
  localparam logic [15:0] DA    = 16'h0100;
  localparam logic [15:0] SA    = 16'h0104;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [15:0] rsp_addr = '0;
  logic [15:0] rsp_data = '0;
  logic        rsp_ready, fifo_empty, fifo_full, overflow;
  logic [3:0]  fifo_count;

  sdr_rd_rsp_fifo_if bus ();

  sdr_rd_rsp_fifo #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO),
    .DATA_ADDR  (DA),
    .STAT_ADDR  (SA)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .bus        (bus),
    .rsp_valid  (rsp_valid),
    .rsp_addr   (rsp_addr),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 pclk = ~pclk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] mq[$];
  logic        movf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mstat();
    int n;
    n = mq.size();
    return {movf, n == DEPTH, n == 0, 13'(n)};
  endfunction

  task automatic push(input logic [15:0] d);
    @(posedge pclk); #1;
    rsp_valid = 1'b1;
    rsp_data  = d;
    rsp_addr  = 16'($urandom);
    @(posedge pclk); #1;
    rsp_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
    else movf = 1'b1;
  endtask

  task automatic apb(input logic wr, input logic [15:0] a,
                     input logic [15:0] wd, output logic [15:0] rd,
                     output logic err, output int ws);
    @(posedge pclk); #1;
    bus.pselect = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = wd;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    ws = 0;
    while (bus.pready !== 1'b1 && ws < 600) begin
      @(posedge pclk); #1;
      ws++;
    end
    if (ws >= 600) chk("apb_bound", {31'b0, bus.pready}, 1);
    rd  = bus.prdata;
    err = bus.pslverr;
    @(posedge pclk); #1;
    bus.pselect = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [15:0] rd, exp;
    logic        err;
    int          ws;
    apb(1'b0, DA, 16'h0, rd, err, ws);
    exp = mq.pop_front();
    chk({tag, "_data"}, {16'h0, rd}, {16'h0, exp});
    chk({tag, "_err"}, {31'b0, err}, 0);
    chk({tag, "_ws"}, ws, 1);
  endtask

  task automatic rd_stat(input string tag, input logic [15:0] exp);
    logic [15:0] rd;
    logic        err;
    int          ws;
    apb(1'b0, SA, 16'h0, rd, err, ws);
    chk({tag, "_stat"}, {16'h0, rd}, {16'h0, exp});
    chk({tag, "_serr"}, {31'b0, err}, 0);
    chk({tag, "_sws"}, ws, 1);
  endtask

  task automatic wr_stat(input logic [15:0] wd);
    logic [15:0] rd;
    logic        err;
    int          ws;
    apb(1'b1, SA, wd, rd, err, ws);
    chk("stat_wr_err", {31'b0, err}, 0);
    if (wd[15]) movf = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd, a, wd;
    logic        err, wr;
    int          ws, op;

    bus.pselect = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pwdata  = '0;

    #12;
    chk("rst_pready", {31'b0, bus.pready}, 0);
    chk("rst_pslverr", {31'b0, bus.pslverr}, 0);
    chk("rst_prdata", {16'h0, bus.prdata}, 0);
    chk("rst_empty", {31'b0, fifo_empty}, 1);
    chk("rst_full", {31'b0, fifo_full}, 0);
    chk("rst_cnt", {28'h0, fifo_count}, 0);
    chk("rst_ready", {31'b0, rsp_ready}, 1);
    chk("rst_ovf", {31'b0, overflow}, 0);
    presetn = 1'b1;

    push(16'h1111);
    push(16'h2222);
    push(16'h3333);
    chk("three_cnt", {28'h0, fifo_count}, 3);
    rd_data("ord0");
    rd_data("ord1");
    rd_data("ord2");
    chk("ord_cnt", {28'h0, fifo_count}, 0);

    for (int i = 0; i < DEPTH; i++) push(16'h1000 + 16'(i));
    @(posedge pclk); #1;
    rsp_valid = 1'b1;
    rsp_data  = 16'hDEAD;
    chk("ovf_ready", {31'b0, rsp_ready}, 0);
    chk("ovf_full", {31'b0, fifo_full}, 1);
    @(posedge pclk); #1;
    rsp_valid = 1'b0;
    movf = 1'b1;
    chk("ovf_flag", {31'b0, overflow}, 1);
    chk("ovf_cnt", {28'h0, fifo_count}, DEPTH);
    rd_stat("ovf", 16'hC008);
    wr_stat(16'h8000);
    rd_stat("clr", 16'h4008);
    for (int i = 0; i < DEPTH; i++) rd_data("drain");

    fork
      apb(1'b0, DA, 16'h0, rd, err, ws);
      begin
        repeat (10) @(posedge pclk);
        push(16'hABCD);
      end
    join
    chk("wait_data", {16'h0, rd}, {16'h0, mq.pop_front()});
    chk("wait_err", {31'b0, err}, 0);

    apb(1'b0, DA, 16'h0, rd, err, ws);
    chk("to_err", {31'b0, err}, 1);
    chk("to_data", {16'h0, rd}, 0);
    chk("to_ws", {31'b0, (ws >= TMO && ws <= TMO + 1)}, 1);
    chk("to_cnt", {28'h0, fifo_count}, 0);

    for (int i = 0; i < 4; i++) push(16'h5000 + 16'(i));
    chk("pp_pre", {28'h0, fifo_count}, 4);
    fork
      apb(1'b0, DA, 16'h0, rd, err, ws);
      begin
        @(posedge pclk);
        push(16'h5004);
        chk("pp_mid", {28'h0, fifo_count}, 4);
      end
    join
    chk("pp_data", {16'h0, rd}, {16'h0, mq.pop_front()});
    chk("pp_cnt", {28'h0, fifo_count}, mq.size());
    apb(1'b0, 16'h0200, 16'h0, rd, err, ws);
    chk("bad_err", {31'b0, err}, 1);
    chk("bad_data", {16'h0, rd}, 0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        push(16'($urandom));
      end else if (op <= 6 && mq.size() > 0) begin
        rd_data("rnd");
      end else if (op == 7) begin
        rd_stat("rnd", mstat());
      end else if (op == 8) begin
        wr_stat(16'($urandom));
      end else begin
        wr = 1'($urandom);
        a  = 16'($urandom);
        if (a == SA || (a == DA && !wr)) a = 16'h0200;
        if (wr && $urandom_range(0, 1) == 1) a = DA;
        wd = 16'($urandom);
        apb(wr, a, wd, rd, err, ws);
        chk("rnd_bad_err", {31'b0, err}, 1);
        chk("rnd_bad_data", {16'h0, rd}, 0);
      end
      chk("rnd_cnt", {28'h0, fifo_count}, mq.size());
      chk("rnd_ovf", {31'b0, overflow}, {31'b0, movf});
    end

    while (mq.size() > 0) rd_data("fin");
    @(posedge pclk); #1;
    bus.pselect = 1'b1;
    bus.pwrite  = 1'b0;
    bus.paddr   = DA;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    repeat (5) @(posedge pclk);
    #2;
    presetn = 1'b0;
    #1;
    chk("mrst_pready", {31'b0, bus.pready}, 0);
    chk("mrst_pslverr", {31'b0, bus.pslverr}, 0);
    chk("mrst_empty", {31'b0, fifo_empty}, 1);
    chk("mrst_cnt", {28'h0, fifo_count}, 0);
    chk("mrst_ovf", {31'b0, overflow}, 0);
    bus.pselect = 1'b0;
    bus.penable = 1'b0;
    movf = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    rd_stat("mrst", mstat());

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
